stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencer and arbiter for the stack pointer: accepts push/pop requests from two requesters (0 = core PUSH/POP/CALL/RET, 1 = interrupt context save/restore) with round-robin arbitration. Performs each stack memory access, then issues exactly one `sp_select` command to the external SP register. Bounds-checks against the stack window so the SP never runs outside it, and never drives the illegal `sp_select` code 2'b11.

## Interface
- STACK_BASE, 32'h2000, SP reset value; lowest stack address, empty-stack SP.
- STACK_DEPTH, 256, number of 32-bit slots; full when sp_addr == STACK_BASE + STACK_DEPTH.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request; held until granted.
- req_op  in  2  per-requester op: 0 = push, 1 = pop; stable while valid.
- req_wdata0, req_wdata1  in  32 each  push data per requester.
- req_gnt  out  2  one-hot grant; a request transfers when req_valid[i] & req_gnt[i].
- resp_valid  out  1  one-cycle completion pulse.
- resp_id  out  1  requester the response belongs to.
- resp_rdata  out  32  pop data; 0 for push or error.
- resp_err  out  1  1 = overflow (push) or underflow (pop); operation not performed.
- mem_req  out  1  memory access request, held until mem_ack.
- mem_we  out  1  1 = write (push), 0 = read (pop).
- mem_addr  out  32  stack slot address.
- mem_wdata  out  32  push data.
- mem_ack  in  1  access complete; read data valid on mem_rdata in the same cycle.
- mem_rdata  in  32  read data.
- sp_select  out  2  00 hold, 01 increment, 10 decrement; 11 never driven.
- sp_addr  in  32  current SP; points to the next free slot (empty-ascending stack).
- stack_count  out  32  sp_addr - STACK_BASE, combinational.

## Operation
- FSM states: IDLE, MEM, UPD, ERR. Reset state is IDLE.
- IDLE: `req_gnt` is combinational, to the single valid requester only.
  - On a tie, grant the requester not granted last. The `last_id` register resets to 1, so requester 0 wins the first tie.
  - On transfer: latch id, op and wdata; update `last_id`.
  - Push with sp_addr == STACK_BASE + STACK_DEPTH, or pop with sp_addr == STACK_BASE: go to ERR.
  - Otherwise: go to MEM.
- MEM:
  - `mem_req` = 1. `mem_we` = 1 for push, 0 for pop.
  - `mem_addr` = sp_addr (push) or sp_addr - 1 (pop), 32-bit wrap-free by the bounds check.
  - `mem_wdata` = latched wdata.
  - Hold all four signals until `mem_ack`. On ack: capture `mem_rdata` for pop, go to UPD.
- UPD (one cycle):
  - `sp_select` = 01 (push) or 10 (pop).
  - `resp_valid` = 1, `resp_err` = 0, `resp_rdata` = captured data (pop) or 0 (push), `resp_id` = latched id.
  - Next state IDLE.
- ERR (one cycle): `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0, `sp_select` = 00, no memory access. Next state IDLE.
- Outside UPD, `sp_select` = 00. Outside MEM, `mem_req` = 0.
- `mem_ack` while `mem_req` = 0 is ignored.
- Reset values: `req_gnt` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_rdata` = 0, `resp_err` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `sp_select` = 00. `stack_count` follows `sp_addr`.
- Reset mid-operation: immediate return to IDLE, `mem_req` drops, the in-flight op is discarded with no response. The SP resets on the same rst_n.

## Timing
- Transfer in cycle T → MEM from T+1. With `mem_ack` at T+1 → UPD at T+2 (`resp_valid`, `sp_select` pulse) → new `sp_addr` visible at T+3, IDLE at T+3.
- Minimum issue interval: 3 cycles. Each `mem_ack` wait cycle adds 1.
- Error path: transfer at T → `resp_valid` with `resp_err` at T+1 → IDLE at T+2.
- `req_gnt` is 0 in every non-IDLE state; requests arriving while busy wait.
- Bounds are checked against `sp_addr` in the transfer cycle. This is always the settled value, since IDLE is never entered in the same cycle as an SP update.

## Test plan
- Single push, req 0, wdata 0xDEADBEEF, ack immediate → mem write at addr 0x2000; `sp_select` = 01 for one cycle; resp id 0, err 0; `stack_count` = 1.
- Push 0x11 then pop, ack delayed 3 cycles → pop reads addr 0x2000, `resp_rdata` = 0x11; `mem_req` held 4 cycles; `sp_addr` back to 0x2000.
- Pop on empty stack → resp err 1 at T+1; no `mem_req`; `sp_select` stays 00.
- Fill 256 pushes, then a 257th push → err 1, `sp_addr` stays 0x2100; a following pop returns the 256th value.
- Both requesters valid continuously (push) → grants alternate 0,1,0,1; responses carry matching `resp_id`.
- rst_n asserted during MEM of a push → `mem_req` 0 immediately; no resp; after release, `stack_count` = 0 and the state is IDLE.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - request, response, memory and SP bundle for stack_ctrl
//
// Purpose: groups every non-clock/reset signal of stack_ctrl into one bundle.
// Ports (all carried as interface signals):
//   req_valid[1:0], req_op[1:0], req_wdata0, req_wdata1  requests from core (0) and interrupt (1)
//   req_gnt[1:0]                                         one-hot grant back to the requesters
//   resp_valid, resp_id, resp_rdata, resp_err            one-cycle completion
//   mem_req, mem_we, mem_addr, mem_wdata                 stack memory access
//   mem_ack, mem_rdata                                   memory completion / read data
//   sp_select[1:0], sp_addr, stack_count                 external SP register control
// Modports: slave = stack_ctrl side, master = requesters / memory / SP side.

interface stack_ctrl_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_wdata0;
   logic [31:0] req_wdata1;
   logic [1:0]  req_gnt;

   logic        resp_valid;
   logic        resp_id;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic [1:0]  sp_select;
   logic [31:0] sp_addr;
   logic [31:0] stack_count;

   modport slave (
      input  req_valid, req_op, req_wdata0, req_wdata1,
      output req_gnt,
      output resp_valid, resp_id, resp_rdata, resp_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output sp_select,
      input  sp_addr,
      output stack_count
   );

   modport master (
      output req_valid, req_op, req_wdata0, req_wdata1,
      input  req_gnt,
      input  resp_valid, resp_id, resp_rdata, resp_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  sp_select,
      output sp_addr,
      input  stack_count
   );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack pointer sequencer with two-requester round-robin arbiter
//
// Purpose: arbitrates push/pop requests from the core (id 0) and the interrupt
// context save/restore engine (id 1), performs the stack memory access, then
// issues exactly one increment/decrement to the external SP register. Pushes on
// a full stack and pops on an empty stack are rejected without touching memory.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    stack_ctrl_if.slave (requests, grant, response, memory, SP control)
// Parameters:
//   STACK_BASE   lowest stack address and empty-stack SP value
//   STACK_DEPTH  number of 32-bit slots; SP == STACK_BASE + STACK_DEPTH is full

module stack_ctrl #(
   parameter logic [31:0] STACK_BASE  = 32'h2000,
   parameter int          STACK_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   stack_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MEM  = 2'd1;
   localparam logic [1:0] S_UPD  = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam logic       OP_PUSH = 1'b0;

   localparam logic [1:0] SP_HOLD = 2'b00;
   localparam logic [1:0] SP_INC  = 2'b01;
   localparam logic [1:0] SP_DEC  = 2'b10;

   localparam logic [31:0] STACK_TOP = STACK_BASE + 32'(STACK_DEPTH);

   logic [1:0]  state_q, state_d;
   logic        last_id_q, last_id_d;
   logic        id_q, id_d;
   logic        op_q, op_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  gnt;
   logic        xfer;
   logic        xfer_id;
   logic        xfer_op;
   logic [31:0] xfer_wdata;
   logic        stack_full;
   logic        stack_empty;

   // Grant only in IDLE. On a tie the requester that did not win last time
   // is served, so last_id resetting to 1 hands the first tie to the core.
   always_comb begin
      gnt = 2'b00;
      if (state_q == S_IDLE) begin
         unique case (bus.req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_id_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign xfer       = |(bus.req_valid & gnt);
   assign xfer_id    = gnt[1];
   assign xfer_op    = xfer_id ? bus.req_op[1] : bus.req_op[0];
   assign xfer_wdata = xfer_id ? bus.req_wdata1 : bus.req_wdata0;

   // Inclusive compares keep the SP inside the window even if it were ever
   // presented outside it; in normal use only the equality cases occur.
   assign stack_full  = (bus.sp_addr >= STACK_TOP);
   assign stack_empty = (bus.sp_addr <= STACK_BASE);

   always_comb begin
      state_d   = state_q;
      last_id_d = last_id_q;
      id_d      = id_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               id_d      = xfer_id;
               op_d      = xfer_op;
               wdata_d   = xfer_wdata;
               last_id_d = xfer_id;
               if ((xfer_op == OP_PUSH) ? stack_full : stack_empty) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_MEM;
               end
            end
         end
         S_MEM: begin
            if (bus.mem_ack) begin
               if (op_q != OP_PUSH) begin
                  rdata_d = bus.mem_rdata;
               end
               state_d = S_UPD;
            end
         end
         S_UPD:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         last_id_q <= 1'b1;
         id_q      <= 1'b0;
         op_q      <= 1'b0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         last_id_q <= last_id_d;
         id_q      <= id_d;
         op_q      <= op_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // All outputs decode from the registered state, so reset forces them to
   // their idle values immediately and mem_req drops with rst_n.
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  sp_select;

   always_comb begin
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
      sp_select  = SP_HOLD;

      unique case (state_q)
         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = (op_q == OP_PUSH);
            // Empty-ascending stack: push writes the free slot, pop reads the
            // slot below it. The bounds check rules out wrap on either side.
            mem_addr  = (op_q == OP_PUSH) ? bus.sp_addr : (bus.sp_addr - 32'd1);
            mem_wdata = wdata_q;
         end
         S_UPD: begin
            resp_valid = 1'b1;
            resp_rdata = (op_q == OP_PUSH) ? 32'd0 : rdata_q;
            sp_select  = (op_q == OP_PUSH) ? SP_INC : SP_DEC;
         end
         S_ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.req_gnt     = gnt;
   assign bus.resp_valid  = resp_valid;
   assign bus.resp_id     = (state_q == S_UPD || state_q == S_ERR) ? id_q : 1'b0;
   assign bus.resp_rdata  = resp_rdata;
   assign bus.resp_err    = resp_err;
   assign bus.mem_req     = mem_req;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;
   assign bus.sp_select   = sp_select;
   assign bus.stack_count = bus.sp_addr - STACK_BASE;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - self-checking bench for stack_ctrl

module tb_stack_ctrl;

   localparam logic [31:0] BASE = 32'h2000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_ctrl_if bus_if ();

   stack_ctrl #(.STACK_BASE(BASE), .STACK_DEPTH(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // External SP register: resets with the controller, steps by one slot.
   logic [31:0] sp_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sp_q <= BASE;
      else if (bus_if.sp_select == 2'b01) sp_q <= sp_q + 32'd1;
      else if (bus_if.sp_select == 2'b10) sp_q <= sp_q - 32'd1;
   end
   assign bus_if.sp_addr = sp_q;

   // Stack memory with programmable ack latency and an injectable stray ack.
   logic [31:0] mem [0:255];
   int unsigned wait_cnt;
   int unsigned ack_delay;
   logic        stray_ack;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= 0;
      else if (bus_if.mem_req && !bus_if.mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end
   assign bus_if.mem_ack   = (bus_if.mem_req && (wait_cnt == ack_delay)) || stray_ack;
   assign bus_if.mem_rdata = mem[bus_if.mem_addr[7:0]];
   always @(posedge clk) begin
      if (bus_if.mem_req && bus_if.mem_ack && bus_if.mem_we)
         mem[bus_if.mem_addr[7:0]] <= bus_if.mem_wdata;
   end

   typedef struct {
      logic        id;
      logic        err;
      logic [31:0] rdata;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int mem_req_cycles, inc_cycles, dec_cycles, accesses, resp_seen;
   logic [31:0] last_addr, last_wdata;
   logic        last_we;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; samples DUT outputs at the falling edge and drains the scoreboard.
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      if (bus_if.mem_req) mem_req_cycles++;
      if (bus_if.mem_req && bus_if.mem_ack) begin
         accesses++;
         last_addr  = bus_if.mem_addr;
         last_we    = bus_if.mem_we;
         last_wdata = bus_if.mem_wdata;
      end
      if (bus_if.sp_select == 2'b01) inc_cycles++;
      if (bus_if.sp_select == 2'b10) dec_cycles++;
      if (bus_if.sp_select == 2'b11) check("sp_select_legal", {30'd0, bus_if.sp_select}, 32'd0);
      if (bus_if.resp_valid) begin
         resp_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_resp", {31'd0, bus_if.resp_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("resp_id", {31'd0, bus_if.resp_id}, {31'd0, e.id});
            check("resp_err", {31'd0, bus_if.resp_err}, {31'd0, e.err});
            check("resp_rdata", bus_if.resp_rdata, e.rdata);
         end
      end
   endtask

   task automatic do_req(input int id, input logic op, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata, input string tag);
      int n;
      int lat;
      exp_t e;
      e.id = id[0]; e.err = exp_err; e.rdata = exp_rdata;
      exp_q.push_back(e);
      mem_req_cycles = 0; inc_cycles = 0; dec_cycles = 0; accesses = 0;
      bus_if.req_valid[id] = 1'b1;
      bus_if.req_op[id]    = op;
      if (id == 0) bus_if.req_wdata0 = wdata;
      else         bus_if.req_wdata1 = wdata;
      #1;
      n = 0;
      while (!bus_if.req_gnt[id] && n < 50) begin
         cyc(); #1; n++;
      end
      check({tag, "_gnt"}, {31'd0, bus_if.req_gnt[id]}, 32'd1);
      cyc();
      bus_if.req_valid[id] = 1'b0;
      lat = 1;
      while (exp_q.size() != 0 && lat < 50) begin
         cyc(); lat++;
      end
      check({tag, "_resp_done"}, exp_q.size(), 32'd0);
      check({tag, "_latency"}, lat, exp_err ? 32'd1 : 32'd2 + ack_delay);
   endtask

   initial begin
      int n;
      int g;
      int seen0;
      exp_t e;

      bus_if.req_valid  = 2'b00;
      bus_if.req_op     = 2'b00;
      bus_if.req_wdata0 = 32'd0;
      bus_if.req_wdata1 = 32'd0;
      ack_delay = 0;
      stray_ack = 1'b0;
      resp_seen = 0;

      // Reset state
      cyc(); cyc();
      check("rst_req_gnt",    {30'd0, bus_if.req_gnt}, 32'd0);
      check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
      check("rst_resp_id",    {31'd0, bus_if.resp_id}, 32'd0);
      check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
      check("rst_resp_err",   {31'd0, bus_if.resp_err}, 32'd0);
      check("rst_mem_req",    {31'd0, bus_if.mem_req}, 32'd0);
      check("rst_mem_we",     {31'd0, bus_if.mem_we}, 32'd0);
      check("rst_mem_addr",   bus_if.mem_addr, 32'd0);
      check("rst_mem_wdata",  bus_if.mem_wdata, 32'd0);
      check("rst_sp_select",  {30'd0, bus_if.sp_select}, 32'd0);
      check("rst_stack_count", bus_if.stack_count, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Push then pop with a 3-cycle ack delay
      ack_delay = 3;
      do_req(0, 1'b0, 32'h0000_0011, 1'b0, 32'd0, "p11_push");
      check("p11_push_addr", last_addr, 32'h2000);
      check("p11_push_req_cycles", mem_req_cycles, 32'd4);
      do_req(1, 1'b1, 32'd0, 1'b0, 32'h0000_0011, "p11_pop");
      check("p11_pop_addr", last_addr, 32'h2000);
      check("p11_pop_we", {31'd0, last_we}, 32'd0);
      check("p11_pop_req_cycles", mem_req_cycles, 32'd4);
      check("p11_pop_dec", dec_cycles, 32'd1);
      cyc();
      check("p11_count", bus_if.stack_count, 32'd0);

      // Pop on an empty stack
      ack_delay = 0;
      do_req(0, 1'b1, 32'd0, 1'b1, 32'd0, "pop_empty");
      check("pop_empty_mem_req", mem_req_cycles, 32'd0);
      check("pop_empty_sp_inc", inc_cycles, 32'd0);
      check("pop_empty_sp_dec", dec_cycles, 32'd0);

      // Stray ack while idle must do nothing
      seen0 = resp_seen;
      stray_ack = 1'b1;
      cyc(); cyc();
      stray_ack = 1'b0;
      cyc();
      check("stray_ack_no_resp", resp_seen, seen0);
      check("stray_ack_count", bus_if.stack_count, 32'd0);

      // Single push, immediate ack
      do_req(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, "push1");
      check("push1_addr", last_addr, 32'h2000);
      check("push1_we", {31'd0, last_we}, 32'd1);
      check("push1_wdata", last_wdata, 32'hDEAD_BEEF);
      check("push1_sp_inc", inc_cycles, 32'd1);
      check("push1_req_cycles", mem_req_cycles, 32'd1);
      cyc();
      check("push1_count", bus_if.stack_count, 32'd1);

      // Fill to 256, overflow, then pop the top
      for (int i = 1; i < 256; i++) begin
         do_req(i & 1, 1'b0, 32'h1000_0000 + i, 1'b0, 32'd0, "fill");
      end
      cyc();
      check("full_count", bus_if.stack_count, 32'd256);
      do_req(1, 1'b0, 32'hBAD0_BAD0, 1'b1, 32'd0, "overflow");
      check("overflow_mem", accesses, 32'd0);
      cyc();
      check("overflow_count", bus_if.stack_count, 32'd256);
      do_req(0, 1'b1, 32'd0, 1'b0, 32'h1000_00FF, "pop_top");
      check("pop_top_addr", last_addr, 32'h20FF);

      // Reset during MEM of a push
      ack_delay = 5;
      seen0 = resp_seen;
      bus_if.req_valid[1] = 1'b1;
      bus_if.req_op[1]    = 1'b0;
      bus_if.req_wdata1   = 32'h5555_AAAA;
      #1;
      n = 0;
      while (!bus_if.req_gnt[1] && n < 50) begin
         cyc(); #1; n++;
      end
      check("rstmid_gnt", {31'd0, bus_if.req_gnt[1]}, 32'd1);
      cyc();
      bus_if.req_valid[1] = 1'b0;
      check("rstmid_in_mem", {31'd0, bus_if.mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_mem_req_drop", {31'd0, bus_if.mem_req}, 32'd0);
      check("rstmid_count_rst", bus_if.stack_count, 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      check("rstmid_no_resp", resp_seen, seen0);
      check("rstmid_count", bus_if.stack_count, 32'd0);
      bus_if.req_valid[0] = 1'b1;
      bus_if.req_op[0]    = 1'b0;
      #1;
      check("rstmid_idle_gnt", {30'd0, bus_if.req_gnt}, 32'd1);
      bus_if.req_valid[0] = 1'b0;

      // Both requesters pushing continuously: grants alternate 0,1,0,1
      ack_delay = 0;
      for (int k = 0; k < 4; k++) begin
         e.id = k[0]; e.err = 1'b0; e.rdata = 32'd0;
         exp_q.push_back(e);
      end
      bus_if.req_op     = 2'b00;
      bus_if.req_wdata0 = 32'hA0A0_0001;
      bus_if.req_wdata1 = 32'hB1B1_0002;
      bus_if.req_valid  = 2'b11;
      #1;
      g = 0; n = 0;
      while (g < 4 && n < 100) begin
         if (bus_if.req_gnt != 2'b00) begin
            check("rr_grant", {30'd0, bus_if.req_gnt}, (g % 2 == 0) ? 32'd1 : 32'd2);
            g++;
         end
         cyc(); n++;
         if (g == 4) bus_if.req_valid = 2'b00;
         #1;
      end
      check("rr_grant_count", g, 32'd4);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         cyc(); n++;
      end
      check("rr_resp_done", exp_q.size(), 32'd0);
      cyc();
      check("rr_count", bus_if.stack_count, 32'd4);

      // LIFO order of the interleaved pushes
      do_req(0, 1'b1, 32'd0, 1'b0, 32'hB1B1_0002, "lifo0");
      do_req(1, 1'b1, 32'd0, 1'b0, 32'hA0A0_0001, "lifo1");
      do_req(0, 1'b1, 32'd0, 1'b0, 32'hB1B1_0002, "lifo2");
      do_req(1, 1'b1, 32'd0, 1'b0, 32'hA0A0_0001, "lifo3");
      cyc();
      check("lifo_count", bus_if.stack_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
